// File: rtl/mips_bus_arbiter_if.sv
// Request/response and Avalon master signal bundle for mips_bus_arbiter.
// The arbiter takes the slave view; the CPU stages and bus take the master view.
interface mips_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        busy;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_write, d_addr, d_wdata, d_byteenable,
        input  waitrequest, readdata,
        output i_done, i_rdata, d_done, d_rdata,
        output address, write, read, writedata, byteenable,
        output busy
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_write, d_addr, d_wdata, d_byteenable,
        output waitrequest, readdata,
        input  i_done, i_rdata, d_done, d_rdata,
        input  address, write, read, writedata, byteenable,
        input  busy
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon master between fetch and load/store, one transfer at a time.
// Define MIPS_ARB_ROUND_ROBIN_EN for round-robin on contention; default is data-first.
module mips_bus_arbiter (
    input  logic              clk,
    input  logic              reset,
    mips_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  be_q, be_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_wins;

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    // 1 = data port owned the most recent completed transfer
    logic lastgnt_q, lastgnt_d;

    assign d_wins = !lastgnt_q;

    always_comb begin
        lastgnt_d = lastgnt_q;
        if (state_q == RESP)
            lastgnt_d = d_done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lastgnt_q <= 1'b0;
        else
            lastgnt_q <= lastgnt_d;
    end
`else
    assign d_wins = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        be_d        = be_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && (d_wins || !bus.i_req)) begin
                    state_d     = BUS_D;
                    address_d   = bus.d_addr;
                    writedata_d = bus.d_wdata;
                    be_d        = bus.d_byteenable;
                    write_d     = bus.d_write;
                    read_d      = !bus.d_write;
                end else if (bus.i_req) begin
                    state_d   = BUS_I;
                    address_d = bus.i_addr;
                    be_d      = 4'hF;
                    write_d   = 1'b0;
                    read_d    = 1'b1;
                end
            end
            BUS_I: begin
                if (!bus.waitrequest) begin
                    state_d   = RESP;
                    read_d    = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = bus.readdata;
                end
            end
            BUS_D: begin
                if (!bus.waitrequest) begin
                    state_d  = RESP;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    d_done_d = 1'b1;
                    if (read_q)
                        d_rdata_d = bus.readdata;
                end
            end
            // requests seen here are ignored so a held req is not re-granted
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= 32'h0;
            writedata_q <= 32'h0;
            be_q        <= 4'h0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.address    = address_q;
    assign bus.writedata  = writedata_q;
    assign bus.byteenable = be_q;
    assign bus.i_done     = i_done_q;
    assign bus.d_done     = d_done_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: vector table, corner sequences, random traffic vs model.
// Honours MIPS_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_bus_arbiter_if bif();

    mips_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

`ifdef MIPS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_i_rdata;
    logic [31:0] exp_d_rdata;
    logic [31:0] mem [16];

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        bit          exp_rd;
        bit          exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.i_req        = 1'b0;
        bif.i_addr       = 32'h0;
        bif.d_req        = 1'b0;
        bif.d_write      = 1'b0;
        bif.d_addr       = 32'h0;
        bif.d_wdata      = 32'h0;
        bif.d_byteenable = 4'h0;
        bif.waitrequest  = 1'b0;
        bif.readdata     = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string t;
        t = $sformatf("v%0d", n);
        if (v.is_d) begin
            bif.d_req        = 1'b1;
            bif.d_write      = v.wr;
            bif.d_addr       = v.addr;
            bif.d_wdata      = v.wdata;
            bif.d_byteenable = v.be;
        end else begin
            bif.i_req  = 1'b1;
            bif.i_addr = v.addr;
        end
        bif.readdata = v.rdata;
        for (int k = 0; k <= v.waits; k++) begin
            tick();
            chk({t, "_rd"}, 32'(bif.read), 32'(v.exp_rd));
            chk({t, "_wr"}, 32'(bif.write), 32'(v.exp_wr));
            chk({t, "_addr"}, bif.address, v.addr);
            chk({t, "_be"}, 32'(bif.byteenable), 32'(v.exp_be));
            if (v.exp_wr)
                chk({t, "_wdata"}, bif.writedata, v.wdata);
            chk({t, "_done_bus"}, 32'({bif.i_done, bif.d_done}), 32'h0);
            chk({t, "_busy"}, 32'(bif.busy), 32'h1);
            bif.waitrequest = (k < v.waits);
        end
        tick();
        if (v.is_d)
            exp_d_rdata = v.exp_rdata;
        else
            exp_i_rdata = v.exp_rdata;
        chk({t, "_done"}, 32'({bif.i_done, bif.d_done}), v.is_d ? 32'h1 : 32'h2);
        chk({t, "_strobe_resp"}, 32'({bif.read, bif.write}), 32'h0);
        chk({t, "_irdata"}, bif.i_rdata, exp_i_rdata);
        chk({t, "_drdata"}, bif.d_rdata, exp_d_rdata);
        idle_inputs();
        tick();
        chk({t, "_done_after"}, 32'({bif.i_done, bif.d_done}), 32'h0);
        chk({t, "_busy_after"}, 32'(bif.busy), 32'h0);
        chk({t, "_strobe_idle"}, 32'({bif.read, bif.write}), 32'h0);
    endtask

    // contention with both requests held; returns the sequence of done owners
    task automatic seq_contention();
        int owners[$];
        int e;
        do_reset();
        bif.i_req        = 1'b1;
        bif.i_addr       = 32'h0000_0100;
        bif.d_req        = 1'b1;
        bif.d_write      = 1'b0;
        bif.d_addr       = 32'h0000_0200;
        bif.d_byteenable = 4'hF;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (bif.i_done) owners.push_back(1);
            if (bif.d_done) owners.push_back(2);
        end
        idle_inputs();
        chk("cont_count", 32'(owners.size()), 32'd4);
        for (int k = 0; k < owners.size() && k < 4; k++) begin
            e = (RR && (k % 2 == 1)) ? 1 : 2;
            chk($sformatf("cont_owner%0d", k), 32'(owners[k]), 32'(e));
        end
        tick();
        chk("cont_idle", 32'(bif.busy), 32'h0);
    endtask

    task automatic seq_hold_done();
        int ns;
        int nd;
        bit prev;
        bit seen;
        bit dropped;
        ns = 0;
        nd = 0;
        prev = 1'b0;
        seen = 1'b0;
        dropped = 1'b0;
        bif.d_req        = 1'b1;
        bif.d_write      = 1'b0;
        bif.d_addr       = 32'h0000_0080;
        bif.d_byteenable = 4'hF;
        bif.readdata     = 32'h1357_2468;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ((bif.read || bif.write) && !prev) ns++;
            prev = bif.read || bif.write;
            if (bif.d_done) nd++;
            if (seen && !dropped) begin
                bif.d_req = 1'b0;
                dropped = 1'b1;
            end
            if (bif.d_done) seen = 1'b1;
        end
        exp_d_rdata = 32'h1357_2468;
        chk("hold_transfers", 32'(ns), 32'd1);
        chk("hold_dones", 32'(nd), 32'd1);
        chk("hold_drdata", bif.d_rdata, exp_d_rdata);
        idle_inputs();
    endtask

    task automatic seq_mid_reset();
        bif.d_req        = 1'b1;
        bif.d_write      = 1'b1;
        bif.d_addr       = 32'h0000_0040;
        bif.d_wdata      = 32'h0000_1234;
        bif.d_byteenable = 4'hF;
        bif.waitrequest  = 1'b1;
        tick();
        chk("mr_write0", 32'(bif.write), 32'h1);
        tick();
        chk("mr_write1", 32'(bif.write), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_write_drop", 32'({bif.read, bif.write}), 32'h0);
        chk("mr_busy", 32'(bif.busy), 32'h0);
        chk("mr_addr", bif.address, 32'h0);
        chk("mr_done0", 32'(bif.d_done), 32'h0);
        @(posedge clk);
        #1;
        chk("mr_done1", 32'(bif.d_done), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_i_rdata = 32'h0;
        exp_d_rdata = 32'h0;
        bif.i_req        = 1'b1;
        bif.i_addr       = 32'h0000_0300;
        bif.d_addr       = 32'h0000_0044;
        bif.d_wdata      = 32'h0000_A5A5;
        bif.d_byteenable = 4'b1100;
        bif.waitrequest  = 1'b0;
        tick();
        chk("mr_grant_wr", 32'({bif.read, bif.write}), 32'h1);
        chk("mr_grant_addr", bif.address, 32'h0000_0044);
        chk("mr_grant_be", 32'(bif.byteenable), 32'hC);
        tick();
        chk("mr_grant_done", 32'({bif.i_done, bif.d_done}), 32'h1);
        idle_inputs();
        tick();
        chk("mr_idle", 32'(bif.busy), 32'h0);
    endtask

    task automatic run_random(input int cycles);
        int act;
        int resp;
        int act_n;
        int resp_n;
        bit mlast_d;
        bit wt;
        bit e_rd;
        bit e_wr;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic [3:0]  r_be;
        bit r_wr;
        do_reset();
        act = 0;
        resp = 0;
        mlast_d = 1'b0;
        r_addr = 32'h0;
        r_wdata = 32'h0;
        r_be = 4'h0;
        r_wr = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            e_rd = (act == 1) || (act == 2 && !r_wr);
            e_wr = (act == 2) && r_wr;
            chk("rnd_rw", 32'({bif.read, bif.write}), 32'({e_rd, e_wr}));
            if (act != 0) begin
                chk("rnd_addr", bif.address, r_addr);
                chk("rnd_be", 32'(bif.byteenable), 32'(r_be));
                if (e_wr)
                    chk("rnd_wdata", bif.writedata, r_wdata);
            end
            chk("rnd_done", 32'({bif.i_done, bif.d_done}),
                32'({resp == 1, resp == 2}));
            chk("rnd_busy", 32'(bif.busy), 32'(act != 0 || resp != 0));
            chk("rnd_irdata", bif.i_rdata, exp_i_rdata);
            chk("rnd_drdata", bif.d_rdata, exp_d_rdata);
            if (resp == 1 || !bif.i_req) begin
                bif.i_req  = (resp == 1) ? 1'($urandom_range(0, 1))
                                         : ($urandom_range(0, 2) == 0);
                bif.i_addr = $urandom;
            end
            if (resp == 2 || !bif.d_req) begin
                bif.d_req        = (resp == 2) ? 1'($urandom_range(0, 1))
                                               : ($urandom_range(0, 2) == 0);
                bif.d_write      = 1'($urandom_range(0, 1));
                bif.d_addr       = $urandom;
                bif.d_wdata      = $urandom;
                bif.d_byteenable = 4'($urandom_range(1, 15));
            end
            wt = ($urandom_range(0, 2) == 0);
            bif.waitrequest = wt;
            bif.readdata = bif.read ? mem[bif.address[5:2]] : $urandom;
            act_n = 0;
            resp_n = 0;
            if (act != 0) begin
                if (!wt) begin
                    if (!r_wr) begin
                        if (act == 1)
                            exp_i_rdata = mem[r_addr[5:2]];
                        else
                            exp_d_rdata = mem[r_addr[5:2]];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (r_be[b])
                                mem[r_addr[5:2]][8*b +: 8] = r_wdata[8*b +: 8];
                    end
                    resp_n = act;
                end else begin
                    act_n = act;
                end
            end else if (resp != 0) begin
                mlast_d = (resp == 2);
            end else if (bif.d_req && (!bif.i_req || !RR || !mlast_d)) begin
                act_n   = 2;
                r_addr  = bif.d_addr;
                r_wdata = bif.d_wdata;
                r_be    = bif.d_byteenable;
                r_wr    = bif.d_write;
            end else if (bif.i_req) begin
                act_n  = 1;
                r_addr = bif.i_addr;
                r_be   = 4'hF;
                r_wr   = 1'b0;
            end
            act = act_n;
            resp = resp_n;
        end
        idle_inputs();
    endtask

    initial begin
        tv[0] = '{1'b0, 1'b0, 32'hBFC0_0000, 32'h0, 4'h0, 0, 32'h2402_0005,
                  4'hF, 1'b1, 1'b0, 32'h2402_0005};
        tv[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3, 32'h5A5A_5A5A,
                  4'b0011, 1'b0, 1'b1, 32'h0000_0000};
        tv[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'hF, 0, 32'hCAFE_F00D,
                  4'hF, 1'b1, 1'b0, 32'hCAFE_F00D};
        tv[3] = '{1'b0, 1'b0, 32'h0040_0010, 32'h0, 4'h0, 2, 32'h8FBF_0018,
                  4'hF, 1'b1, 1'b0, 32'h8FBF_0018};
        tv[4] = '{1'b1, 1'b0, 32'h0000_0003, 32'h0, 4'b0100, 1, 32'h1122_3344,
                  4'b0100, 1'b1, 1'b0, 32'h1122_3344};
        tv[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 4'hF, 0, 32'h5A5A_5A5A,
                  4'hF, 1'b0, 1'b1, 32'h1122_3344};
        tv[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 5, 32'hFFFF_FFFF,
                  4'hF, 1'b1, 1'b0, 32'hFFFF_FFFF};
        for (int i = 0; i < 16; i++)
            mem[i] = $urandom;

        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst_strobes", 32'({bif.read, bif.write}), 32'h0);
            chk("rst_addr", bif.address, 32'h0);
            chk("rst_wdata", bif.writedata, 32'h0);
            chk("rst_be", 32'(bif.byteenable), 32'h0);
            chk("rst_done", 32'({bif.i_done, bif.d_done}), 32'h0);
            chk("rst_rdata", bif.i_rdata | bif.d_rdata, 32'h0);
            chk("rst_busy", 32'(bif.busy), 32'h0);
        end

        for (int n = 0; n < 7; n++)
            run_vec(tv[n], n);

        seq_hold_done();
        seq_contention();
        seq_mid_reset();
        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-port arbiter that shares the CPU's single Avalon memory-mapped master bus between the instruction-fetch unit and the load/store unit. Each requester issues one transfer at a time with a simple req/done handshake. The arbiter latches the winning request, drives the Avalon signals until `waitrequest` deasserts, and returns read data with a one-cycle `done` pulse. It sits between the CPU core's fetch/memory stages and the top-level bus ports.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_req`  in  1  instruction fetch request (read only)
- `i_addr`  in  32  fetch byte address
- `i_done`  out  1  one-cycle pulse: fetch complete, `i_rdata` valid
- `i_rdata`  out  32  fetched word, held until the next fetch completes
- `d_req`  in  1  data request
- `d_write`  in  1  1 = store, 0 = load
- `d_addr`  in  32  data byte address
- `d_wdata`  in  32  store data
- `d_byteenable`  in  4  store/load lane enables
- `d_done`  out  1  one-cycle pulse: data transfer complete
- `d_rdata`  out  32  load word, held until the next data transfer completes
- `address`  out  32  Avalon address
- `write`  out  1  Avalon write strobe
- `read`  out  1  Avalon read strobe
- `waitrequest`  in  1  Avalon stall
- `writedata`  out  32  Avalon write data
- `byteenable`  out  4  Avalon lane enables
- `readdata`  in  32  Avalon read data, valid when `read` is high and `waitrequest` is low
- `busy`  out  1  high when state is not IDLE

## Operation
- FSM states: IDLE, BUS_I, BUS_D, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - One requester: grant it.
  - Both requesters: arbitration policy decides (see Configuration).
  - On grant, latch `addr`, `wdata`, `byteenable` and `write` into output registers, then go to BUS_I or BUS_D.
- BUS_I: `read`=1, `write`=0, `byteenable`=4'hF, `address` = latched `i_addr`.
- BUS_D: `read`=!latched write, `write`=latched write, other bus fields from the latched data request.
- In a BUS state with `waitrequest`=1: hold all bus outputs stable.
- In a BUS state with `waitrequest`=0:
  - Transfer completes.
  - For a read, capture `readdata` into `i_rdata` or `d_rdata`.
  - Drop `read`/`write` in the next cycle and go to RESP.
- RESP:
  - Assert the granted port's `done` for exactly one cycle.
  - Update the last-granted pointer.
  - Return to IDLE.
  - No arbitration occurs in RESP, so a requester may hold `req` high through its `done` cycle without a duplicate grant.
- Requester rules:
  - Hold `req` and all request fields stable from assertion until `done`.
  - `req` still high in the first IDLE cycle after `done` means a new request.
- Changes to request inputs after the grant are ignored, because fields are latched.
- `d_write`=1 never returns data; `d_rdata` is unchanged.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE
  - `read`=0, `write`=0, `address`=0, `writedata`=0, `byteenable`=0
  - `i_done`=0, `d_done`=0, `i_rdata`=0, `d_rdata`=0, `busy`=0
  - last-granted = instruction
- Zero-wait transfer takes 3 cycles:
  - cycle 0: IDLE, grant
  - cycle 1: bus strobe asserted, `waitrequest`=0
  - cycle 2: RESP, `done`=1
- Each `waitrequest`=1 cycle adds one cycle.
- `i_rdata`/`d_rdata` are valid in the `done` cycle and held afterwards.
- Peak throughput: one transfer per 3 cycles.
- Reset asserted mid-transfer drops strobes immediately, even though this violates Avalon hold rules. Reset has priority; no `done` is generated.
- Exactly one of `read`/`write` is high in a BUS state. Both are 0 in IDLE and RESP.

## Configuration
- `MIPS_ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests in IDLE, grant the port that was not last granted.
  - The pointer updates in RESP.
- `MIPS_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: data always wins over instruction.
  - The pointer is unused.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset then idle: all outputs are 0 and `busy`=0 for 10 cycles with no requests.
- `i_req`=1, `i_addr`=0xBFC00000, `waitrequest`=0, `readdata`=0x24020005:
  - `read`=1 with `address`=0xBFC00000 and `byteenable`=F in cycle 1.
  - `i_done`=1 with `i_rdata`=0x24020005 in cycle 2.
- Store with stall: `d_write`=1, `d_addr`=0x1000, `d_wdata`=0xDEADBEEF, `d_byteenable`=4'b0011, `waitrequest`=1 for 3 cycles:
  - `write` and all fields stay stable for 4 cycles.
  - `d_done` pulses once.
  - `d_rdata` is unchanged.
- Simultaneous `i_req` and `d_req`, held continuously, all zero-wait:
  - With the macro: grants alternate D, I, D, I.
  - Without the macro: D is granted every time and I starves.
- Hold `d_req` through `d_done`, then drop it: exactly one transfer is issued, with no duplicate.
- Assert `reset` while in BUS_D with `waitrequest`=1:
  - `write` goes 0 immediately and no `d_done` is generated.
  - After release, the first contention grants D.
